// File: rtl/context_switch_unit.sv
// context_switch_unit
//
// Per-process PC save/restore stage placed after the round-robin scheduler.
// Keeps a process control table (one saved PC + valid bit per process). A switch
// request stalls the core, saves the outgoing PC, fetches the incoming PC and
// hands it back with a one-cycle load strobe (or a one-cycle error pulse when
// the incoming entry is not valid).
//
// Ports:
//   clock, reset       single clock, synchronous active-high reset
//   troca_contexto     switch request pulse (with processo_saida/entrada, pc)
//   criar, criar_id,   create-process strobe, id and start PC
//   criar_pc
//   stall              high while a switch is in progress (SAVE/LOAD/RESUME)
//   pc_novo            PC to load into the processor (held between switches)
//   carregar_pc        one-cycle strobe: processor loads pc_novo
//   processo_ativo     id currently owning the CPU
//   erro_contexto      one-cycle pulse: incoming id had no valid entry
//   contagem_trocas    completed-switch counter (only with CTX_SWITCH_COUNT_EN)
//
// Optional feature macro: CTX_SWITCH_COUNT_EN adds the contagem_trocas counter.

module context_switch_unit #(
    parameter int unsigned ID_WIDTH = 3,
    parameter int unsigned PC_WIDTH = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                troca_contexto,
    input  logic [ID_WIDTH-1:0] processo_saida,
    input  logic [ID_WIDTH-1:0] processo_entrada,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                criar,
    input  logic [ID_WIDTH-1:0] criar_id,
    input  logic [PC_WIDTH-1:0] criar_pc,
    output logic                stall,
    output logic [PC_WIDTH-1:0] pc_novo,
    output logic                carregar_pc,
    output logic [ID_WIDTH-1:0] processo_ativo,
`ifdef CTX_SWITCH_COUNT_EN
    output logic [31:0]         contagem_trocas,
`endif
    output logic                erro_contexto
);

    localparam int unsigned Depth = 1 << ID_WIDTH;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSave   = 2'd1;
    localparam logic [1:0] StLoad   = 2'd2;
    localparam logic [1:0] StResume = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [ID_WIDTH-1:0] out_id_q, out_id_d;
    logic [ID_WIDTH-1:0] in_id_q, in_id_d;
    logic [PC_WIDTH-1:0] pc_lat_q, pc_lat_d;
    logic [PC_WIDTH-1:0] pc_novo_q, pc_novo_d;
    logic [ID_WIDTH-1:0] ativo_q, ativo_d;
    logic                carregar_q, carregar_d;
    logic                erro_q, erro_d;
    logic [Depth-1:0]    valid_q, valid_d;

    // PC table is deliberately not reset; valid bits gate every read.
    logic [PC_WIDTH-1:0] pcb_pc [Depth];

    // Single table write port: criar in IDLE and the save in SAVE never overlap.
    logic                wr_en;
    logic [ID_WIDTH-1:0] wr_idx;
    logic [PC_WIDTH-1:0] wr_data;

    always_comb begin
        state_d    = state_q;
        out_id_d   = out_id_q;
        in_id_d    = in_id_q;
        pc_lat_d   = pc_lat_q;
        pc_novo_d  = pc_novo_q;
        ativo_d    = ativo_q;
        carregar_d = 1'b0;
        erro_d     = 1'b0;
        valid_d    = valid_q;
        wr_en      = 1'b0;
        wr_idx     = criar_id;
        wr_data    = criar_pc;

        case (state_q)
            StIdle: begin
                if (troca_contexto) begin
                    out_id_d = processo_saida;
                    in_id_d  = processo_entrada;
                    pc_lat_d = pc;
                    state_d  = StSave;
                end
                if (criar) begin
                    wr_en             = 1'b1;
                    valid_d[criar_id] = 1'b1;
                end
            end
            StSave: begin
                // Save before load so a same-id switch returns the sampled pc.
                wr_en   = 1'b1;
                wr_idx  = out_id_q;
                wr_data = pc_lat_q;
                state_d = StLoad;
            end
            StLoad: begin
                // Outputs are registered here so they are valid throughout RESUME.
                if (valid_q[in_id_q]) begin
                    pc_novo_d  = pcb_pc[in_id_q];
                    ativo_d    = in_id_q;
                    carregar_d = 1'b1;
                end else begin
                    erro_d = 1'b1;
                end
                state_d = StResume;
            end
            StResume: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            out_id_q   <= '0;
            in_id_q    <= '0;
            pc_lat_q   <= '0;
            pc_novo_q  <= '0;
            ativo_q    <= '0;
            carregar_q <= 1'b0;
            erro_q     <= 1'b0;
            valid_q    <= Depth'(1);
        end else begin
            state_q    <= state_d;
            out_id_q   <= out_id_d;
            in_id_q    <= in_id_d;
            pc_lat_q   <= pc_lat_d;
            pc_novo_q  <= pc_novo_d;
            ativo_q    <= ativo_d;
            carregar_q <= carregar_d;
            erro_q     <= erro_d;
            valid_q    <= valid_d;
        end
    end

    // Reset also blocks writes, so an interrupted SAVE-edge write cannot land.
    always_ff @(posedge clock) begin
        if (!reset && wr_en) begin
            pcb_pc[wr_idx] <= wr_data;
        end
    end

`ifdef CTX_SWITCH_COUNT_EN
    logic [31:0] count_q;

    // Counts on the edge closing the carregar_pc cycle; wraps naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (carregar_q) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign contagem_trocas = count_q;
`endif

    assign stall          = (state_q != StIdle);
    assign pc_novo        = pc_novo_q;
    assign carregar_pc    = carregar_q;
    assign processo_ativo = ativo_q;
    assign erro_contexto  = erro_q;

endmodule

// File: tb/tb_context_switch_unit.sv
// Self-checking bench for context_switch_unit: directed scenarios followed by
// randomized switches/creates compared against a table-level reference model.

module tb_context_switch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        troca_contexto;
    logic [2:0]  processo_saida;
    logic [2:0]  processo_entrada;
    logic [31:0] pc;
    logic        criar;
    logic [2:0]  criar_id;
    logic [31:0] criar_pc;
    logic        stall;
    logic [31:0] pc_novo;
    logic        carregar_pc;
    logic [2:0]  processo_ativo;
    logic        erro_contexto;
`ifdef CTX_SWITCH_COUNT_EN
    logic [31:0] contagem_trocas;
`endif

    always #5 clock = ~clock;

    context_switch_unit #(
        .ID_WIDTH(3),
        .PC_WIDTH(32)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .troca_contexto  (troca_contexto),
        .processo_saida  (processo_saida),
        .processo_entrada(processo_entrada),
        .pc              (pc),
        .criar           (criar),
        .criar_id        (criar_id),
        .criar_pc        (criar_pc),
        .stall           (stall),
        .pc_novo         (pc_novo),
        .carregar_pc     (carregar_pc),
        .processo_ativo  (processo_ativo),
`ifdef CTX_SWITCH_COUNT_EN
        .contagem_trocas (contagem_trocas),
`endif
        .erro_contexto   (erro_contexto)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: the process table plus the visible output state.
    logic [31:0] m_pc    [8];
    bit          m_valid [8];
    bit          m_known [8];
    logic [2:0]  m_ativo;
    logic [31:0] m_novo;
    logic [31:0] m_count;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m_valid[k] = 1'b0;
        m_valid[0] = 1'b1;
        m_ativo    = 3'd0;
        m_novo     = 32'd0;
        m_count    = 32'd0;
    endtask

    task automatic model_criar(input logic [2:0] id, input logic [31:0] p);
        m_pc[id]    = p;
        m_valid[id] = 1'b1;
        m_known[id] = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_stall"}, 64'(stall), 64'(0));
        check({tag, "_carregar"}, 64'(carregar_pc), 64'(0));
        check({tag, "_erro"}, 64'(erro_contexto), 64'(0));
        check({tag, "_pc_novo"}, 64'(pc_novo), 64'(m_novo));
        check({tag, "_ativo"}, 64'(processo_ativo), 64'(m_ativo));
`ifdef CTX_SWITCH_COUNT_EN
        check({tag, "_count"}, 64'(contagem_trocas), 64'(m_count));
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        check_idle("reset");
    endtask

    task automatic noise_inputs(input bit en);
        troca_contexto   = en ? 1'($urandom) : 1'b0;
        processo_saida   = 3'($urandom);
        processo_entrada = 3'($urandom);
        pc               = $urandom;
        criar            = en ? 1'($urandom) : 1'b0;
        criar_id         = 3'($urandom);
        criar_pc         = $urandom;
    endtask

    task automatic idle_criar(input logic [2:0] id, input logic [31:0] p);
        criar    = 1'b1;
        criar_id = id;
        criar_pc = p;
        tick();
        criar = 1'b0;
        model_criar(id, p);
    endtask

    // Full switch starting from IDLE; optional simultaneous create and
    // ignored-request noise during the busy cycles.
    task automatic do_switch(input logic [2:0] o, input logic [2:0] i, input logic [31:0] p,
                             input bit with_criar, input logic [2:0] cid,
                             input logic [31:0] cpc, input bit noise);
        bit ok;
        troca_contexto   = 1'b1;
        processo_saida   = o;
        processo_entrada = i;
        pc               = p;
        criar            = with_criar;
        criar_id         = cid;
        criar_pc         = cpc;
        tick();
        if (with_criar) model_criar(cid, cpc);
        m_pc[o]    = p;
        m_known[o] = 1'b1;
        ok         = m_valid[i];
        if (ok) begin
            m_novo  = m_pc[i];
            m_ativo = i;
        end
        noise_inputs(noise);
        check("save_stall", 64'(stall), 64'(1));
        check("save_carregar", 64'(carregar_pc), 64'(0));
        tick();
        noise_inputs(noise);
        check("load_stall", 64'(stall), 64'(1));
        tick();
        noise_inputs(noise);
        check("resume_stall", 64'(stall), 64'(1));
        check("resume_carregar", 64'(carregar_pc), 64'(ok));
        check("resume_erro", 64'(erro_contexto), 64'(!ok));
        check("resume_pc_novo", 64'(pc_novo), 64'(m_novo));
        check("resume_ativo", 64'(processo_ativo), 64'(m_ativo));
        tick();
        noise_inputs(1'b0);
        if (ok) m_count = m_count + 32'd1;
        check_idle("after");
    endtask

    initial begin
        reset = 1'b0;
        noise_inputs(1'b0);
        for (int k = 0; k < 8; k++) begin
            m_pc[k]    = 32'd0;
            m_known[k] = 1'b0;
        end
        model_reset();
        tick();
        do_reset();

        // Directed scenarios
        idle_criar(3'd1, 32'h100);
        do_switch(3'd0, 3'd1, 32'h44, 1'b0, 3'd0, 32'd0, 1'b0);
        do_switch(3'd1, 3'd0, 32'h120, 1'b0, 3'd0, 32'd0, 1'b0);
        do_switch(3'd0, 3'd1, 32'h48, 1'b0, 3'd0, 32'd0, 1'b0);
        do_switch(3'd1, 3'd5, 32'h130, 1'b0, 3'd0, 32'd0, 1'b0);
        idle_criar(3'd2, 32'h200);
        do_switch(3'd2, 3'd2, 32'h300, 1'b0, 3'd0, 32'd0, 1'b1);
        do_switch(3'd1, 3'd2, 32'h140, 1'b0, 3'd0, 32'd0, 1'b0);
        // Create and switch in the same cycle, incoming id is the created one
        do_switch(3'd2, 3'd6, 32'h310, 1'b1, 3'd6, 32'h600, 1'b0);
        // Create on an already-valid id overwrites its PC
        idle_criar(3'd1, 32'h1000);
        do_switch(3'd6, 3'd1, 32'h610, 1'b0, 3'd0, 32'd0, 1'b0);

        // Reset in the LOAD cycle of a switch
        troca_contexto   = 1'b1;
        processo_saida   = 3'd1;
        processo_entrada = 3'd2;
        pc               = 32'h1040;
        tick();
        troca_contexto = 1'b0;
        m_pc[1]        = 32'h1040;
        tick();
        do_reset();
        do_switch(3'd0, 3'd1, 32'h50, 1'b0, 3'd0, 32'd0, 1'b0);
        do_switch(3'd0, 3'd0, 32'h54, 1'b0, 3'd0, 32'd0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            logic [2:0]  o;
            logic [2:0]  i;
            int          idles;
            idles = int'($urandom_range(0, 2));
            for (int k = 0; k < idles; k++) begin
                if ($urandom_range(0, 1) == 1) idle_criar(3'($urandom), $urandom);
                else tick();
            end
            o = 3'($urandom);
            i = 3'($urandom);
            if (m_valid[i] && !m_known[i]) i = o;
            do_switch(o, i, $urandom, 1'($urandom), 3'($urandom), $urandom,
                      1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/context_switch_unit.md
# context_switch_unit

Per-process PC save/restore stage that sits directly downstream of the round-robin scheduler. It holds a process control table of one saved PC plus a valid bit per process. On each scheduler switch request it stalls the processor, stores the outgoing process's PC and fetches the incoming one. It then hands the fetched PC back to the fetch stage with a one-cycle load strobe.

## Interface

Parameters:
- `ID_WIDTH`, default 3: process-id width; table depth is 2**ID_WIDTH.
- `PC_WIDTH`, default 32: PC width.

Ports:
- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `troca_contexto`  in  1  switch request pulse from scheduler.
- `processo_saida`  in  ID_WIDTH  outgoing process id, valid with `troca_contexto`.
- `processo_entrada`  in  ID_WIDTH  incoming process id, valid with `troca_contexto`.
- `pc`  in  PC_WIDTH  processor's current PC, sampled with `troca_contexto`.
- `criar`  in  1  create-process strobe.
- `criar_id`  in  ID_WIDTH  id of the process being created.
- `criar_pc`  in  PC_WIDTH  start PC of the process being created.
- `stall`  out  1  freeze processor fetch/commit.
- `pc_novo`  out  PC_WIDTH  PC to load into the processor.
- `carregar_pc`  out  1  one-cycle strobe: processor loads `pc_novo`.
- `processo_ativo`  out  ID_WIDTH  id currently owning the CPU.
- `erro_contexto`  out  1  one-cycle pulse: incoming id has no valid entry.

## Operation

- Table: `pcb_pc[2**ID_WIDTH]` and `pcb_valid[2**ID_WIDTH]`.
- Reset:
  - Clears all valid bits, then sets `pcb_valid[0]=1`. Table PCs are not cleared.
  - All outputs go to 0, including `processo_ativo=0`.
  - State returns to IDLE. This applies from any state, including mid-switch.
- FSM states: IDLE, SAVE, LOAD, RESUME.
  - IDLE:
    - If `troca_contexto`=1, latch `processo_saida`, `processo_entrada` and `pc`, then go to SAVE.
    - If `criar`=1, write `pcb_pc[criar_id]=criar_pc` and `pcb_valid[criar_id]=1`.
    - Both requests are honoured in the same cycle.
  - SAVE: write `pcb_pc[out]=latched pc`; go to LOAD.
  - LOAD:
    - If `pcb_valid[in]`, register `pc_novo=pcb_pc[in]` and set a load flag.
    - Otherwise set an error flag.
    - Go to RESUME.
  - RESUME:
    - On load flag: pulse `carregar_pc` and update `processo_ativo=in`.
    - On error flag: pulse `erro_contexto`; `processo_ativo` and `pc_novo` are unchanged.
    - Go to IDLE.
- `stall`=1 in SAVE, LOAD and RESUME; 0 in IDLE.
- `troca_contexto` or `criar` arriving outside IDLE is ignored (dropped, no queueing).
- `processo_saida == processo_entrada`: the full sequence runs. SAVE precedes LOAD, so `pc_novo` equals the sampled `pc`.
- The outgoing PC is saved even when the incoming entry is invalid. The outgoing entry's valid bit is not changed by SAVE.
- `criar` on an already-valid id overwrites its PC.

## Timing

- Request sampled at edge T (state IDLE):
  - T+1: SAVE, `stall`=1.
  - T+2: LOAD.
  - T+3: RESUME; `carregar_pc` or `erro_contexto` high for exactly this cycle; `pc_novo` and `processo_ativo` valid from this cycle on.
  - T+4: IDLE, `stall`=0.
- Switch latency is 3 cycles from request to `carregar_pc`. `stall` is asserted for 3 cycles.
- The earliest next accepted request is at edge T+4. Scheduler quantum must be at least 4.
- `criar` write is visible to a LOAD of the same id starting from the following cycle.
- `pc_novo` holds its value between switches.

## Configuration

- Macro: `CTX_SWITCH_COUNT_EN`.
- Defined:
  - Adds output `contagem_trocas`  out  32  count of completed switches.
  - Increments in the cycle `carregar_pc` is pulsed; error switches are not counted.
  - Wraps from 0xFFFFFFFF to 0; reset value 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

## Test plan

- Reset, then `criar` id 1 with pc 0x100. Request 0→1 with `pc`=0x44 → `stall` high for 3 cycles; at T+3 `carregar_pc`=1, `pc_novo`=0x100, `processo_ativo`=1; `pcb_pc[0]`=0x44.
- Request 1→0 with `pc`=0x120 → `pc_novo`=0x44 at T+3; a following 0→1 request returns `pc_novo`=0x120.
- Request 0→5 with id 5 never created → `erro_contexto` pulse at T+3, no `carregar_pc`, `processo_ativo` stays 0, `pcb_pc[0]` updated.
- Request 2→2 (valid) with `pc`=0x300 → `pc_novo`=0x300. A second `troca_contexto` at T+1 and a `criar` at T+2 are both ignored (table entry unchanged).
- Assert `reset` at T+2 of a switch → next cycle `stall`=0, `carregar_pc`=0, `processo_ativo`=0, only entry 0 valid. With `CTX_SWITCH_COUNT_EN` defined, `contagem_trocas`=0.
- With `CTX_SWITCH_COUNT_EN` defined, 3 good switches plus 1 erroneous switch → `contagem_trocas`=3.
